// File: rtl/loader_pkg.sv
// Shared types for the UART word loader: loader and receiver state encodings
// and the default baud divisor.
package loader_pkg;

  typedef enum logic [1:0] {
    LD_WAIT_DELIM = 2'd0,
    LD_LOAD       = 2'd1,
    LD_DONE       = 2'd2
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int DEFAULT_CLK_PER_BIT = 16;

endpackage

// File: rtl/uart_word_loader_if.sv
// Single-port memory write bus driven by the loader (master) into instruction
// memory (slave).
interface uart_word_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              WE;
  logic [ADDR_W-1:0] WADDR;
  logic [DATA_W-1:0] WDATA;

  modport master (output WE, WADDR, WDATA);
  modport slave  (input  WE, WADDR, WDATA);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle
// byte_valid / frame_err pulses.
module uart_rx_core
  import loader_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);

  logic      rx_s1_q, rx_s2_q, prev_q;
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic bv_q, bv_d, fe_q, fe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_s2_q) state_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        // A line that is high again at mid start bit was a glitch.
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d  = {rx_s2_q, sh_q[7:1]};
        if (bit_q == 3'd7) state_d = RX_STOP;
        else               bit_d   = bit_q + 3'd1;
      end
      RX_STOP: if (cnt_q == FULL) begin
        cnt_d   = '0;
        state_d = RX_IDLE;
        if (rx_s2_q) bv_d = 1'b1;
        else         fe_d = 1'b1;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      prev_q  <= rx_s2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
    end
  end

  assign byte_valid_o = bv_q;
  assign byte_o       = sh_q;
  assign frame_err_o  = fe_q;

endmodule

// File: rtl/uart_word_loader.sv
// UART program loader: assembles big-endian words and writes a delimiter-framed
// payload to memory. Optional macro LOADER_CHECKSUM_EN adds a CHECKSUM output.
module uart_word_loader
  import loader_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int WORD_BYTES  = 4,
  parameter int ADDR_W      = 10,
  parameter logic [WORD_BYTES*8-1:0] DELIM = '1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                UART_RX,
  input  logic                CLEAR,
  uart_word_loader_if.master  wr,
  output logic                BUSY,
  output logic                DONE,
  output logic [ADDR_W:0]     WORD_COUNT,
  output logic                FRAME_ERR,
  output logic                OVERFLOW
`ifdef LOADER_CHECKSUM_EN
  , output logic [WORD_BYTES*8-1:0] CHECKSUM
`endif
);
  localparam int W     = WORD_BYTES * 8;
  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int CW    = ADDR_W + 1;
  localparam logic [CW-1:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  logic       byte_valid, frame_err, word_valid;
  logic [7:0] rx_byte;
  logic [W-1:0] asm_word;

  loader_state_e state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W-1:0]      word_q, word_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [CW-1:0]     count_q, count_d;
  logic we_q, we_d, ferr_q, ferr_d, ovf_q, ovf_d;
`ifdef LOADER_CHECKSUM_EN
  logic [W-1:0] csum_q, csum_d;
`endif

  uart_rx_core #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .rx_i        (UART_RX),
    .byte_valid_o(byte_valid),
    .byte_o      (rx_byte),
    .frame_err_o (frame_err)
  );

  assign asm_word = W'({word_q, rx_byte});

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    count_d    = count_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    ferr_d     = ferr_q;
    ovf_d      = ovf_q;
    word_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (CLEAR) begin
      state_d = LD_WAIT_DELIM;
      idx_d   = '0;
      addr_d  = '0;
      count_d = '0;
      ferr_d  = 1'b0;
      ovf_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else begin
      if (frame_err) begin
        ferr_d = 1'b1;
        idx_d  = '0;
      end else if (byte_valid) begin
        word_d = asm_word;
        if (idx_q == IDX_W'(WORD_BYTES - 1)) begin
          idx_d      = '0;
          word_valid = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      if (word_valid) begin
        case (state_q)
          LD_WAIT_DELIM: if (asm_word == DELIM) begin
            state_d = LD_LOAD;
            addr_d  = '0;
            count_d = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
          end
          LD_LOAD: begin
            if (asm_word == DELIM) begin
              state_d = LD_DONE;
            end else if (count_q == CAP) begin
              ovf_d   = 1'b1;
              state_d = LD_DONE;
            end else begin
              we_d    = 1'b1;
              waddr_d = addr_q;
              wdata_d = asm_word;
              addr_d  = addr_q + ADDR_W'(1);
              count_d = count_q + CW'(1);
`ifdef LOADER_CHECKSUM_EN
              csum_d  = csum_q + asm_word;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= LD_WAIT_DELIM;
      idx_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign wr.WE      = we_q;
  assign wr.WADDR   = waddr_q;
  assign wr.WDATA   = wdata_q;
  assign BUSY       = (state_q == LD_LOAD);
  assign DONE       = (state_q == LD_DONE);
  assign WORD_COUNT = count_q;
  assign FRAME_ERR  = ferr_q;
  assign OVERFLOW   = ovf_q;
`ifdef LOADER_CHECKSUM_EN
  assign CHECKSUM   = csum_q;
`endif

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader with a word-level reference model and a
// per-cycle write-port checker.
module tb_uart_word_loader;
  localparam int CPB    = 8;
  localparam int ADDR_W = 2;
  localparam int CAPW   = 1 << ADDR_W;
  localparam logic [31:0] DLM = 32'hFFFF_FFFF;

  logic CLK = 1'b0, RST_N = 1'b0, UART_RX = 1'b1, CLEAR = 1'b0;
  logic BUSY, DONE, FRAME_ERR, OVERFLOW;
  logic [ADDR_W:0] WORD_COUNT;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] CHECKSUM;
`endif

  uart_word_loader_if #(.ADDR_W(ADDR_W), .DATA_W(32)) wr_if ();

  uart_word_loader #(.CLK_PER_BIT(CPB), .WORD_BYTES(4), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .UART_RX(UART_RX), .CLEAR(CLEAR), .wr(wr_if),
    .BUSY(BUSY), .DONE(DONE), .WORD_COUNT(WORD_COUNT),
    .FRAME_ERR(FRAME_ERR), .OVERFLOW(OVERFLOW)
`ifdef LOADER_CHECKSUM_EN
    , .CHECKSUM(CHECKSUM)
`endif
  );

  always #5 CLK = ~CLK;

  int vectors = 0, miscompares = 0;

  typedef struct { logic [ADDR_W-1:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];

  // Word-level reference: 0 = waiting for delimiter, 1 = loading, 2 = done.
  int          mstate = 0, mcount = 0;
  bit          mfe = 0, movf = 0;
  logic [31:0] msum = 0, mlast_d = 0;
  logic [ADDR_W-1:0] mlast_a = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_word(input logic [31:0] w);
    wr_t e;
    case (mstate)
      0: if (w == DLM) begin mstate = 1; mcount = 0; msum = 0; end
      1: begin
        if (w == DLM) mstate = 2;
        else if (mcount == CAPW) begin movf = 1; mstate = 2; end
        else begin
          e.a = mcount[ADDR_W-1:0]; e.d = w;
          exp_q.push_back(e);
          mlast_a = e.a; mlast_d = w;
          msum = msum + w;
          mcount++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_clear();
    mstate = 0; mcount = 0; mfe = 0; movf = 0; msum = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    UART_RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (CPB) @(negedge CLK);
    end
    UART_RX = stop;
    repeat (CPB) @(negedge CLK);
    UART_RX = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic send_word(input logic [31:0] w);
    model_word(w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
    repeat (3) @(negedge CLK);
  endtask

  task automatic pulse_clear();
    @(negedge CLK);
    CLEAR = 1'b1;
    @(negedge CLK);
    CLEAR = 1'b0;
    model_clear();
    @(negedge CLK);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_done"},  {31'd0, DONE},      {31'd0, mstate == 2});
    check({tag, "_busy"},  {31'd0, BUSY},      {31'd0, mstate == 1});
    check({tag, "_count"}, 32'(WORD_COUNT),    32'(mcount));
    check({tag, "_ferr"},  {31'd0, FRAME_ERR}, {31'd0, mfe});
    check({tag, "_ovf"},   {31'd0, OVERFLOW},  {31'd0, movf});
    check({tag, "_waddr"}, 32'(wr_if.WADDR),   32'(mlast_a));
    check({tag, "_wdata"}, wr_if.WDATA,        mlast_d);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check({tag, "_csum"},  CHECKSUM,           msum);
`endif
  endtask

  // Every write strobe must match the next write the model predicts.
  always @(negedge CLK) begin
    if (RST_N && wr_if.WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("we_waddr", 32'(wr_if.WADDR), 32'(e.a));
        check("we_wdata", wr_if.WDATA, e.d);
      end
    end
  end

  initial begin
    repeat (80000) @(posedge CLK);
    $display("FAIL watchdog: run did not finish, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_we",    {31'd0, wr_if.WE}, 32'd0);
    check("rst_busy",  {31'd0, BUSY}, 32'd0);
    check("rst_done",  {31'd0, DONE}, 32'd0);
    check("rst_count", 32'(WORD_COUNT), 32'd0);
    check("rst_ferr",  {31'd0, FRAME_ERR}, 32'd0);
    check("rst_waddr", 32'(wr_if.WADDR), 32'd0);
    check("rst_wdata", wr_if.WDATA, 32'd0);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);

    // Basic framed load of three words.
    send_word(DLM);
    check("t1_busy_lit", {31'd0, BUSY}, 32'd1);
    send_word(32'hA400_0000);
    send_word(32'hA000_0000);
    send_word(32'hC800_0000);
    send_word(DLM);
    check_status("t1");
    check("t1_count_lit", 32'(WORD_COUNT), 32'd3);
    check("t1_waddr_hold_lit", 32'(wr_if.WADDR), 32'd2);
    send_word(32'h5555_5555);
    check_status("t1_ignored");
    pulse_clear();
    check_status("clr1");
    check("clr1_done_lit", {31'd0, DONE}, 32'd0);

    // Words before the delimiter are discarded.
    send_word(32'h1234_5678);
    send_word(DLM);
    send_word(32'hDEAD_BEEF);
    send_word(DLM);
    check_status("t2");
    check("t2_wdata_lit", wr_if.WDATA, 32'hDEAD_BEEF);
    check("t2_count_lit", 32'(WORD_COUNT), 32'd1);
    pulse_clear();

    // Framing error drops the partial word.
    send_word(DLM);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b0);
    mfe = 1;
    repeat (3) @(negedge CLK);
    send_word(32'h1122_3344);
    send_word(DLM);
    check_status("t3");
    check("t3_ferr_lit", {31'd0, FRAME_ERR}, 32'd1);
    pulse_clear();
    check_status("clr3");

    // Overflow at capacity of 2**ADDR_W words.
    send_word(DLM);
    for (int i = 1; i <= 5; i++) send_word(32'h0000_0010 * i + 32'(i));
    check_status("t4");
    check("t4_ovf_lit", {31'd0, OVERFLOW}, 32'd1);
    check("t4_count_lit", 32'(WORD_COUNT), 32'd4);
    pulse_clear();

    // Asynchronous reset in the middle of a byte while loading.
    send_word(DLM);
    send_word(32'h0A0B_0C0D);
    UART_RX = 1'b0;
    repeat (3 * CPB) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("t5_rst_busy",  {31'd0, BUSY}, 32'd0);
    check("t5_rst_count", 32'(WORD_COUNT), 32'd0);
    check("t5_rst_wdata", wr_if.WDATA, 32'd0);
    model_clear();
    mlast_a = 0; mlast_d = 0;
    UART_RX = 1'b1;
    repeat (5) @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    send_word(DLM);
    send_word(32'h0102_0304);
    send_word(DLM);
    check_status("t5");
    check("t5_waddr_lit", 32'(wr_if.WADDR), 32'd0);
    pulse_clear();

`ifdef LOADER_CHECKSUM_EN
    send_word(DLM);
    send_word(32'h0000_0001);
    send_word(32'hFFFF_FFFE);
    send_word(32'h0000_0005);
    send_word(DLM);
    check_status("t6");
    check("t6_csum_lit", CHECKSUM, 32'h0000_0004);
    pulse_clear();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
Synthesizable program/data loader for the CPU core. It receives a UART byte stream, assembles big-endian words of WORD_BYTES bytes, and frames a load with a delimiter word. Each payload word is written into instruction memory through a single write port with an auto-incrementing address. It replaces the behavioural host-side loading used in simulation with a parametrised hardware block: configurable baud divisor, word width and depth, error detection, and completion status.

Parameters:
CLK_PER_BIT, 16, clock cycles per UART bit (baud divisor); must be ≥4.
WORD_BYTES, 4, bytes per assembled word; first received byte is the MSB.
ADDR_W, 10, write-address width; capacity is 2**ADDR_W words.
DELIM, all-ones of WORD_BYTES*8 bits, delimiter word value.

Ports:
CLK  in  1  system clock, all logic on the rising edge.
RST_N  in  1  asynchronous active-low reset.
UART_RX  in  1  serial input, idle high, 8N1, LSB first.
CLEAR  in  1  single-cycle pulse: return to WAIT_DELIM and clear status.
WE  out  1  one-cycle write strobe.
WADDR  out  ADDR_W  write address.
WDATA  out  WORD_BYTES*8  write data.
BUSY  out  1  high in LOAD state.
DONE  out  1  high in DONE state.
WORD_COUNT  out  ADDR_W+1  number of payload words written.
FRAME_ERR  out  1  sticky: stop bit sampled low.
OVERFLOW  out  1  sticky: payload exceeded capacity.
CHECKSUM  out  WORD_BYTES*8  only with LOADER_CHECKSUM_EN.

Behaviour:
- Reset: all outputs 0; FSM is WAIT_DELIM; byte index 0; address 0; RX synchroniser preset to 1.
- RX path: two-flop synchroniser.
  - A falling edge in RX_IDLE starts a bit counter.
  - At CLK_PER_BIT/2 the start bit is resampled; if it is 1, this is a false start and the path returns to RX_IDLE.
  - Data bits are then sampled every CLK_PER_BIT, LSB first.
  - The stop bit is sampled at its mid-bit. Stop = 1 gives a one-cycle byte_valid. Stop = 0 sets FRAME_ERR, discards the byte, and resets the byte index to 0, dropping any partial word.
  - After the stop-bit sample the path returns to RX_IDLE immediately, so back-to-back frames are accepted.
- Word assembly: bytes shift in MSB-first. On the WORD_BYTES-th byte, word_valid pulses in the same cycle as byte_valid and the byte index wraps to 0.
- Loader FSM:
  - WAIT_DELIM: a word equal to DELIM moves to LOAD with address 0; any other word is discarded.
  - LOAD:
    - A non-DELIM word drives WE = 1, WADDR = current address and WDATA = word for exactly one cycle, one cycle after word_valid. The address and WORD_COUNT then increment.
    - A DELIM word moves to DONE with no write.
    - A word arriving when WORD_COUNT == 2**ADDR_W is not written; it sets OVERFLOW and moves to DONE.
  - DONE: ignores all further words. The RX path keeps running and FRAME_ERR is still updated. Stays in DONE until CLEAR.
- CLEAR, from any state: FSM to WAIT_DELIM; address, WORD_COUNT, byte index, FRAME_ERR and OVERFLOW cleared; checksum cleared.
- CLEAR coinciding with word_valid or byte_valid: CLEAR wins and the word or byte is dropped.
- RST_N asserted mid-frame or mid-write: immediate return to reset state; WE drops asynchronously.
- WADDR and WDATA hold their last written values between strobes.

Optional Feature:
LOADER_CHECKSUM_EN defined:
- CHECKSUM port exists.
- Each written word is added modulo 2**(WORD_BYTES*8) into an accumulator, updated in the same cycle WE is high.
- Delimiter words are excluded.
- The accumulator is cleared on reset, on CLEAR, and on entry to LOAD.

LOADER_CHECKSUM_EN undefined:
- No CHECKSUM port and no accumulator logic.

Decomposition:
- Shared package loader_pkg: loader state enum (WAIT_DELIM, LOAD, DONE), RX state enum (RX_IDLE, RX_START, RX_DATA, RX_STOP), and the default CLK_PER_BIT constant.
- One sub-module, uart_rx_core (CLK_PER_BIT parameter), provides the synchroniser, bit timing, byte_valid and frame_err. uart_word_loader handles assembly, the FSM and status.

Test Plan:
1. Send FFFFFFFF, A4000000, A0000000, C8000000, FFFFFFFF → three WE pulses at WADDR 0,1,2 with the matching WDATA; then DONE=1, WORD_COUNT=3, FRAME_ERR=0.
2. Send 12345678 before FFFFFFFF, then DEADBEEF, FFFFFFFF → only DEADBEEF written, at WADDR 0; WORD_COUNT=1.
3. In LOAD, corrupt the stop bit of the 2nd byte of a word, then send 11223344 cleanly → FRAME_ERR=1; partial word dropped; 11223344 written intact.
4. With ADDR_W=2, send delimiter then five payload words → four writes at addresses 0–3; 5th word sets OVERFLOW=1 and DONE=1, no 5th WE.
5. Assert RST_N low mid-byte, release, then send a full load → clean restart with correct words from WADDR 0. Separately, pulse CLEAR in DONE → state WAIT_DELIM and all status cleared.
6. With LOADER_CHECKSUM_EN, load 00000001, FFFFFFFE, 00000005 → CHECKSUM=00000004 (wrap-around).
